// File: rtl/lif_synapse_current_gen.sv
// Synaptic front end for the LIF neuron: weights incoming spikes, registers the
// weighted sum, and integrates it into a decaying 8-bit post-synaptic current.
// Optional feature macro: SYN_EVENT_COUNT_EN (saturating received-spike counter).
module lif_synapse_current_gen #(
    parameter int N_INPUTS    = 4,
    parameter int DECAY_SHIFT = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic [N_INPUTS-1:0] spike_in,
    input  logic                wr_en,
    input  logic [2:0]          wr_addr,
    input  logic [7:0]          wr_data,
    input  logic                clear,
    output logic [7:0]          current_out,
    output logic                sat_flag,
    output logic [15:0]         event_count
);

    localparam int SUM_W = 8 + $clog2(N_INPUTS);
    // One bit above the sum width so the integration result can never wrap.
    localparam int NXT_W = SUM_W + 1;

    logic [7:0]       weight [N_INPUTS];
    logic [SUM_W-1:0] sum_c;
    logic [SUM_W-1:0] sum_r;
    logic [NXT_W-1:0] nxt;
    logic             nxt_sat;

    // Weight table: writes land at the edge, so a same-edge spike sees the old value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < N_INPUTS; i++) begin
                weight[i] <= '0;
            end
        end else if (wr_en) begin
            for (int unsigned i = 0; i < N_INPUTS; i++) begin
                if (wr_addr == 3'(i)) begin
                    weight[i] <= wr_data;
                end
            end
        end
    end

    // Weighted sum of the spikes present this cycle.
    always_comb begin
        sum_c = '0;
        for (int unsigned i = 0; i < N_INPUTS; i++) begin
            if (spike_in[i]) begin
                sum_c = sum_c + SUM_W'(weight[i]);
            end
        end
    end

    // Decay the present current and add the registered sum.
    always_comb begin
        nxt = NXT_W'(current_out) - NXT_W'(current_out >> DECAY_SHIFT) + NXT_W'(sum_r);
        nxt_sat = (nxt > NXT_W'(255));
    end

    // Two-stage pipeline: sum register then saturating current integrator.
    // A disabled edge holds sum_r so a pending sum is consumed on the next enabled edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sum_r       <= '0;
            current_out <= '0;
            sat_flag    <= 1'b0;
        end else if (clear) begin
            sum_r       <= '0;
            current_out <= '0;
            sat_flag    <= 1'b0;
        end else if (enable) begin
            sum_r       <= sum_c;
            current_out <= nxt_sat ? 8'hFF : nxt[7:0];
            sat_flag    <= nxt_sat;
        end
    end

`ifdef SYN_EVENT_COUNT_EN
    logic [3:0]  spike_pop;
    logic [16:0] count_sum;

    // Number of spikes on this cycle and the unsaturated running total.
    always_comb begin
        spike_pop = '0;
        for (int unsigned i = 0; i < N_INPUTS; i++) begin
            spike_pop = spike_pop + 4'(spike_in[i]);
        end
        count_sum = {1'b0, event_count} + 17'(spike_pop);
    end

    // Saturating received-spike counter, untouched by clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            event_count <= '0;
        end else if (enable && !clear) begin
            event_count <= count_sum[16] ? 16'hFFFF : count_sum[15:0];
        end
    end
`else
    assign event_count = '0;
`endif

endmodule

// File: tb/tb_lif_synapse_current_gen.sv
// Self-checking bench for lif_synapse_current_gen: directed scenarios with literal
// expectations plus randomized traffic against a behavioural model.
module tb_lif_synapse_current_gen;

    localparam int N  = 4;
    localparam int DS = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [N-1:0] spike_in;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [7:0]  wr_data;
    logic        clear;
    logic [7:0]  current_out;
    logic        sat_flag;
    logic [15:0] event_count;

    lif_synapse_current_gen #(.N_INPUTS(N), .DECAY_SHIFT(DS)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .spike_in   (spike_in),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .clear      (clear),
        .current_out(current_out),
        .sat_flag   (sat_flag),
        .event_count(event_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model state
    int m_w [N];
    int m_pend;
    int m_cur;
    int m_sat;
    int m_cnt;
    bit chk_on = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_on) begin
            check("current_out", int'(current_out), m_cur);
            check("sat_flag", int'(sat_flag), m_sat);
`ifdef SYN_EVENT_COUNT_EN
            check("event_count", int'(event_count), m_cnt);
`else
            check("event_count_tied", int'(event_count), 0);
`endif
        end
    end

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_w[i] = 0;
        m_pend = 0;
        m_cur  = 0;
        m_sat  = 0;
        m_cnt  = 0;
    endtask

    // Drive one cycle of inputs, advance the model at the edge, return at negedge.
    task automatic step(input bit en, input bit clr, input logic [N-1:0] spk,
                        input bit we, input int wa, input int wd);
        int s;
        int nxt;
        enable   = en;
        clear    = clr;
        spike_in = spk;
        wr_en    = we;
        wr_addr  = wa[2:0];
        wr_data  = wd[7:0];
        @(posedge clk);
        s = 0;
        for (int i = 0; i < N; i++) if (spk[i]) s += m_w[i];
        if (we && wa < N) m_w[wa] = wd;
        if (clr) begin
            m_pend = 0;
            m_cur  = 0;
            m_sat  = 0;
        end else if (en) begin
            nxt    = m_cur - m_cur / (2 ** DS) + m_pend;
            m_sat  = (nxt > 255) ? 1 : 0;
            m_cur  = (nxt > 255) ? 255 : nxt;
            m_pend = s;
            m_cnt  = m_cnt + $countones(spk);
            if (m_cnt > 65535) m_cnt = 65535;
        end
        @(negedge clk);
    endtask

    task automatic idle();
        step(1'b1, 1'b0, '0, 1'b0, 0, 0);
    endtask

    // Asynchronous reset between edges; outputs must clear without a clock.
    task automatic do_reset();
        #1 reset = 1'b1;
        #1;
        check("reset_current", int'(current_out), 0);
        check("reset_sat", int'(sat_flag), 0);
        check("reset_count", int'(event_count), 0);
        model_reset();
        #1 reset = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1);
    end

    initial begin
        bit             prev_pend;
        bit             en;
        bit             clr;
        logic [N-1:0]   spk;
        int             r;

        reset = 1'b1; enable = 1'b0; clear = 1'b0; spike_in = '0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        model_reset();
        #2;
        check("init_current", int'(current_out), 0);
        check("init_sat", int'(sat_flag), 0);
        reset = 1'b0;
        @(negedge clk);
        chk_on = 1'b1;

        // T2 decay
        step(1, 0, '0, 1, 0, 'h40);
        step(1, 0, 4'b0001, 0, 0, 0);
        idle(); check("t2_0x40", int'(current_out), 'h40);
        idle(); check("t2_0x30", int'(current_out), 'h30);
        idle(); check("t2_0x24", int'(current_out), 'h24);
        idle(); check("t2_0x1b", int'(current_out), 'h1B);
        for (int i = 0; i < 20; i++) idle();

        // T3 saturation
        for (int i = 0; i < N; i++) step(1, 0, '0, 1, i, 'hFF);
        step(1, 1, '0, 0, 0, 0);
        step(1, 0, 4'hF, 0, 0, 0);
        step(1, 0, 4'hF, 0, 0, 0);
        check("t3_sat_cur", int'(current_out), 'hFF);
        check("t3_sat_flag", int'(sat_flag), 1);
        step(1, 0, 4'hF, 0, 0, 0);
        idle();
        check("t3_sat_flag_last", int'(sat_flag), 1);
        idle();
        check("t3_decay_cur", int'(current_out), 192);
        check("t3_decay_flag", int'(sat_flag), 0);

        // T4 write/spike collision
        step(1, 1, '0, 1, 1, 'h20);
        step(1, 0, 4'b0010, 1, 1, 'h10);
        step(1, 0, 4'b0010, 0, 0, 0);
        check("t4_old_weight", int'(current_out), 'h20);
        idle();
        check("t4_new_weight", int'(current_out), 'h28);

        // T5 enable/clear
        step(1, 1, '0, 1, 0, 'h30);
        step(1, 0, 4'b0001, 0, 0, 0);
        idle();
        check("t5_start", int'(current_out), 'h30);
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 4'b0101, 0, 0, 0);
            check("t5_hold", int'(current_out), 'h30);
        end
        step(0, 1, '0, 0, 0, 0);
        check("t5_clear", int'(current_out), 0);
        step(1, 0, 4'b0001, 0, 0, 0);
        idle();
        check("t5_weight_kept", int'(current_out), 'h30);

        // T1 reset mid-run
        step(1, 1, '0, 1, 0, 'h80);
        step(1, 0, 4'b0001, 0, 0, 0);
        idle();
        check("t1_pre", int'(current_out), 'h80);
        do_reset();
        step(1, 0, 4'b0001, 0, 0, 0);
        idle();
        check("t1_weights_zero", int'(current_out), 0);

`ifdef SYN_EVENT_COUNT_EN
        // T6 event counter
        do_reset();
        step(1, 0, 4'b0011, 0, 0, 0);
        step(1, 0, 4'b1000, 0, 0, 0);
        step(1, 0, 4'b1111, 0, 0, 0);
        check("t6_count7", int'(event_count), 7);
        while (m_cnt < 65534 - 4) step(1, 0, 4'hF, 0, 0, 0);
        r = 65534 - m_cnt;
        spk = N'((1 << r) - 1);
        step(1, 0, spk, 0, 0, 0);
        check("t6_fffe", int'(event_count), 'hFFFE);
        step(1, 0, 4'hF, 0, 0, 0);
        check("t6_ffff", int'(event_count), 'hFFFF);
        step(1, 0, 4'hF, 0, 0, 0);
        check("t6_hold_ffff", int'(event_count), 'hFFFF);
`endif

        // Randomized traffic; enable only drops when no sum is pending.
        prev_pend = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            en  = ($urandom_range(0, 9) < 8) || prev_pend;
            clr = ($urandom_range(0, 99) < 3);
            spk = N'($urandom);
            step(en, clr, spk, ($urandom_range(0, 4) == 0),
                 int'($urandom_range(0, 7)), int'($urandom_range(0, 255)));
            prev_pend = en && !clr && (spk != '0);
        end

        chk_on = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
